// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin arbiter sharing one hex display path among four requesters
module hex_display_arbiter #(
    parameter int DWELL = 50_000_000,
    parameter int WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_data,
    input  logic                 freeze,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     disp_value,
    output logic [1:0]           disp_src,
    output logic                 disp_valid,
    output logic                 busy
);

    // One spare bit above log2(DWELL) so DWELL=1 still gets a 1-bit counter.
    localparam int               CNT_W    = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           last_grant_q, last_grant_d;
    logic [WIDTH-1:0]     disp_value_q, disp_value_d;
    logic [1:0]           disp_src_q, disp_src_d;
    logic                 disp_valid_q, disp_valid_d;
    logic [3:0]           ack_q, ack_d;

    logic [WIDTH-1:0]     slice [4];
    logic                 found;
    logic [1:0]           winner;
    logic [1:0]           cand;

    // Split the packed request data bus into one value per requester.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slice[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: start just after the last winner, first set request wins.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // State and datapath registers; reset abandons any dwell in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 2'd3;
            disp_value_q <= '0;
            disp_src_q   <= '0;
            disp_valid_q <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            disp_value_q <= disp_value_d;
            disp_src_q   <= disp_src_d;
            disp_valid_q <= disp_valid_d;
            ack_q        <= ack_d;
        end
    end

    // Next-state logic: grant from IDLE, count down the dwell in HOLD.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        disp_value_d = disp_value_q;
        disp_src_d   = disp_src_q;
        disp_valid_d = disp_valid_q;
        ack_d        = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    disp_value_d  = slice[winner];
                    disp_src_d    = winner;
                    last_grant_d  = winner;
                    ack_d[winner] = 1'b1;
                    disp_valid_d  = 1'b1;
                    cnt_d         = CNT_LOAD;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (!freeze) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack        = ack_q;
    assign disp_value = disp_value_q;
    assign disp_src   = disp_src_q;
    assign disp_valid = disp_valid_q;
    assign busy       = (state_q == HOLD);

endmodule
